// File: rtl/register_file_bypass.sv
// Two-read, one-write register file with byte write enables and optional same-cycle write-to-read forwarding.
// Latency: reads are combinational (zero cycles); writes land at the next rising edge of clk.
// Backpressure: none; every write is accepted, and both read ports are always valid.
module register_file_bypass #(
  parameter int                N_BITS   = 32,
  parameter int                N_REGS   = 32,
  parameter int                ZERO_REG = 1,
  parameter int                BYPASS   = 1,
  parameter int                SP_INDEX = 29,
  parameter logic [N_BITS-1:0] SP_RESET = N_BITS'(32'h7FFF_EFFC),
  parameter int                GP_INDEX = 28,
  parameter logic [N_BITS-1:0] GP_RESET = N_BITS'(32'h1000_8000),
  localparam int               ADDR_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  localparam int               N_BYTES   = (N_BITS >= 8) ? N_BITS / 8 : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [N_BYTES-1:0]   wbe,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [N_BITS-1:0]    wdata,
  input  logic [ADDR_BITS-1:0] raddr_a,
  input  logic [ADDR_BITS-1:0] raddr_b,
  output logic [N_BITS-1:0]    rdata_a,
  output logic [N_BITS-1:0]    rdata_b
);

  // Reject configurations that cannot be built as described.
  if (N_BITS < 8 || (N_BITS % 8) != 0) begin : g_bad_width
    $error("register_file_bypass: N_BITS must be a multiple of 8, at least 8");
  end
  if (N_REGS < 2 || (N_REGS & (N_REGS - 1)) != 0) begin : g_bad_regs
    $error("register_file_bypass: N_REGS must be a power of two, at least 2");
  end
  if (SP_INDEX < 0 || SP_INDEX >= N_REGS || (ZERO_REG != 0 && SP_INDEX == 0)) begin : g_bad_sp
    $error("register_file_bypass: SP_INDEX out of range or aliases the zero register");
  end
  if (GP_INDEX < 0 || GP_INDEX >= N_REGS || (ZERO_REG != 0 && GP_INDEX == 0)) begin : g_bad_gp
    $error("register_file_bypass: GP_INDEX out of range or aliases the zero register");
  end

  logic [N_BITS-1:0] regs [N_REGS];

  // Writes to register 0 are dropped when it is hardwired, so its storage stays at its reset value of zero.
  logic wr_en;
  assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

  // Forwarding is only live outside reset; during reset the write is discarded, so reads must not show it.
  logic fwd_en;
  assign fwd_en = we && !reset && (BYPASS != 0);

  // Read data: zero register first, then byte-wise merge of the in-flight write over stored contents.
  function automatic logic [N_BITS-1:0] read_port(
    input logic [ADDR_BITS-1:0] addr,
    input logic [N_BITS-1:0]    stored,
    input logic                 fwd,
    input logic [ADDR_BITS-1:0] wr_addr,
    input logic [N_BYTES-1:0]   wr_be,
    input logic [N_BITS-1:0]    wr_data
  );
    logic [N_BITS-1:0] v;
    v = stored;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      v = '0;
    end else if (fwd && (addr == wr_addr)) begin
      for (int k = 0; k < N_BYTES; k++) begin
        if (wr_be[k]) begin
          v[8*k +: 8] = wr_data[8*k +: 8];
        end
      end
    end
    return v;
  endfunction

  // Storage update: synchronous reset loads the pointer values, otherwise byte-enabled write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (i == SP_INDEX) begin
          regs[i] <= SP_RESET;
        end else if (i == GP_INDEX) begin
          regs[i] <= GP_RESET;
        end else begin
          regs[i] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int k = 0; k < N_BYTES; k++) begin
        if (wbe[k]) begin
          regs[waddr][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
    end
  end

  // Both read ports are independent combinational lookups of the same storage.
  always_comb begin
    rdata_a = read_port(raddr_a, regs[raddr_a], fwd_en, waddr, wbe, wdata);
    rdata_b = read_port(raddr_b, regs[raddr_b], fwd_en, waddr, wbe, wdata);
  end

endmodule

// File: tb/tb_register_file_bypass.sv
module tb_register_file_bypass;

  // Shared stimulus for the default (forwarding) instance and the non-forwarding instance.
  logic        clk;
  logic        reset;
  logic        we;
  logic [3:0]  wbe;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic [31:0] rdata_a_nb;
  logic [31:0] rdata_b_nb;

  // Small instance for the randomised run.
  logic        r_reset;
  logic        r_we;
  logic [1:0]  r_wbe;
  logic [2:0]  r_waddr;
  logic [15:0] r_wdata;
  logic [2:0]  r_ra;
  logic [2:0]  r_rb;
  logic [15:0] r_rda;
  logic [15:0] r_rdb;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [15:0] r_q[$];
  logic [15:0] model[8];

  typedef struct {
    logic        rst;
    logic        w;
    logic [3:0]  be;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a;
    logic [4:0]  b;
    logic        adv;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ena;
    logic [31:0] enb;
  } step_t;

  register_file_bypass dut (
    .clk(clk), .reset(reset), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b)
  );

  register_file_bypass #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a_nb), .rdata_b(rdata_b_nb)
  );

  register_file_bypass #(.N_BITS(16), .N_REGS(8), .SP_INDEX(5), .GP_INDEX(6)) dut_r (
    .clk(clk), .reset(r_reset), .we(r_we), .wbe(r_wbe), .waddr(r_waddr), .wdata(r_wdata),
    .raddr_a(r_ra), .raddr_b(r_rb), .rdata_a(r_rda), .rdata_b(r_rdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one step's inputs and queue its four expected read values.
  task automatic apply(input step_t s);
    reset   = s.rst;
    we      = s.w;
    wbe     = s.be;
    waddr   = s.wa;
    wdata   = s.wd;
    raddr_a = s.a;
    raddr_b = s.b;
    exp_q.push_back(s.ea);
    exp_q.push_back(s.eb);
    exp_q.push_back(s.ena);
    exp_q.push_back(s.enb);
  endtask

  task automatic test_reset();
    step_t s[$];
    logic [31:0] obs[4];
    logic [31:0] e;
    reset = 1'b1; we = 1'b0; tick();
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd0,  5'd28, 1'b0, 32'h0, 32'h1000_8000, 32'h0, 32'h1000_8000});
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd29, 5'd5,  1'b0, 32'h7FFF_EFFC, 32'h0, 32'h7FFF_EFFC, 32'h0});
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      obs = '{rdata_a, rdata_b, rdata_a_nb, rdata_b_nb};
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[j] !== e) begin
          failures++;
          $display("FAIL reset step%0d out%0d got %h want %h", i, j, obs[j], e);
        end
      end
      if (s[i].adv) tick();
    end
  endtask

  task automatic test_write_bytes();
    step_t s[$];
    logic [31:0] obs[4];
    logic [31:0] e;
    s.push_back('{1'b0, 1'b1, 4'hF, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0});
    s.push_back('{1'b0, 1'b0, 4'hF, 5'd5, 32'h0, 5'd5, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    s.push_back('{1'b0, 1'b1, 4'h3, 5'd5, 32'h1234_5678, 5'd5, 5'd5, 1'b1, 32'hDEAD_5678, 32'hDEAD_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 32'hDEAD_5678, 32'hDEAD_5678, 32'hDEAD_5678, 32'hDEAD_5678});
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      obs = '{rdata_a, rdata_b, rdata_a_nb, rdata_b_nb};
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[j] !== e) begin
          failures++;
          $display("FAIL write_bytes step%0d out%0d got %h want %h", i, j, obs[j], e);
        end
      end
      if (s[i].adv) tick();
    end
  endtask

  task automatic test_zero_reg();
    step_t s[$];
    logic [31:0] obs[4];
    logic [31:0] e;
    s.push_back('{1'b0, 1'b1, 4'hF, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd5, 1'b1, 32'h0, 32'hDEAD_5678, 32'h0, 32'hDEAD_5678});
    for (int n = 0; n < 3; n++)
      s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0});
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      obs = '{rdata_a, rdata_b, rdata_a_nb, rdata_b_nb};
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[j] !== e) begin
          failures++;
          $display("FAIL zero_reg step%0d out%0d got %h want %h", i, j, obs[j], e);
        end
      end
      if (s[i].adv) tick();
    end
  endtask

  task automatic test_bypass();
    step_t s[$];
    logic [31:0] obs[4];
    logic [31:0] e;
    s.push_back('{1'b0, 1'b1, 4'hF, 5'd7, 32'hAAAA_AAAA, 5'd7, 5'd5, 1'b1, 32'hAAAA_AAAA, 32'hDEAD_5678, 32'h0, 32'hDEAD_5678});
    s.push_back('{1'b0, 1'b1, 4'hC, 5'd7, 32'h5555_5555, 5'd7, 5'd7, 1'b1, 32'h5555_AAAA, 32'h5555_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA});
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 32'h5555_AAAA, 32'h5555_AAAA, 32'h5555_AAAA, 32'h5555_AAAA});
    // Forwarding only applies to the addressed register; port B reads a different one.
    s.push_back('{1'b0, 1'b1, 4'hF, 5'd31, 32'h0BAD_F00D, 5'd31, 5'd7, 1'b1, 32'h0BAD_F00D, 32'h5555_AAAA, 32'h0, 32'h5555_AAAA});
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd31, 5'd31, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D});
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      obs = '{rdata_a, rdata_b, rdata_a_nb, rdata_b_nb};
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[j] !== e) begin
          failures++;
          $display("FAIL bypass step%0d out%0d got %h want %h", i, j, obs[j], e);
        end
      end
      if (s[i].adv) tick();
    end
  endtask

  task automatic test_no_write();
    step_t s[$];
    logic [31:0] obs[4];
    logic [31:0] e;
    s.push_back('{1'b0, 1'b1, 4'h0, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd7, 1'b1, 32'h0, 32'h5555_AAAA, 32'h0, 32'h5555_AAAA});
    s.push_back('{1'b0, 1'b0, 4'hF, 5'd9, 32'hFFFF_FFFF, 5'd9, 5'd7, 1'b1, 32'h0, 32'h5555_AAAA, 32'h0, 32'h5555_AAAA});
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0});
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      obs = '{rdata_a, rdata_b, rdata_a_nb, rdata_b_nb};
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[j] !== e) begin
          failures++;
          $display("FAIL no_write step%0d out%0d got %h want %h", i, j, obs[j], e);
        end
      end
      if (s[i].adv) tick();
    end
  endtask

  task automatic test_reset_priority();
    step_t s[$];
    logic [31:0] obs[4];
    logic [31:0] e;
    s.push_back('{1'b0, 1'b1, 4'hF, 5'd29, 32'h1234_5678, 5'd29, 5'd5, 1'b1, 32'h1234_5678, 32'hDEAD_5678, 32'h7FFF_EFFC, 32'hDEAD_5678});
    // Reset raised with a write to SP: stored data still visible, no forwarding.
    s.push_back('{1'b1, 1'b1, 4'hF, 5'd29, 32'h0000_0001, 5'd29, 5'd5, 1'b1, 32'h1234_5678, 32'hDEAD_5678, 32'h1234_5678, 32'hDEAD_5678});
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd29, 5'd5, 1'b1, 32'h7FFF_EFFC, 32'h0, 32'h7FFF_EFFC, 32'h0});
    s.push_back('{1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 5'd28, 5'd7, 1'b1, 32'h1000_8000, 32'h0, 32'h1000_8000, 32'h0});
    foreach (s[i]) begin
      apply(s[i]);
      #1;
      obs = '{rdata_a, rdata_b, rdata_a_nb, rdata_b_nb};
      for (int j = 0; j < 4; j++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs[j] !== e) begin
          failures++;
          $display("FAIL reset_priority step%0d out%0d got %h want %h", i, j, obs[j], e);
        end
      end
      if (s[i].adv) tick();
    end
  endtask

  // Reference read of the small instance: zero register, then byte merge of a live write.
  function automatic logic [15:0] model_read(input logic [2:0] addr);
    logic [15:0] v;
    if (addr == 3'd0) return 16'h0;
    v = model[addr];
    if (!r_reset && r_we && addr == r_waddr) begin
      if (r_wbe[0]) v[7:0]  = r_wdata[7:0];
      if (r_wbe[1]) v[15:8] = r_wdata[15:8];
    end
    return v;
  endfunction

  task automatic test_random();
    logic [15:0] e;
    r_reset = 1'b1; r_we = 1'b0; tick();
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    model[5] = 16'hEFFC;
    model[6] = 16'h8000;
    for (int c = 0; c < 10000; c++) begin
      r_reset = ($urandom_range(63) == 0);
      r_we    = ($urandom_range(3) != 0);
      r_wbe   = 2'($urandom_range(3));
      r_waddr = 3'($urandom_range(7));
      r_wdata = 16'($urandom);
      r_ra    = ($urandom_range(3) == 0) ? r_waddr : 3'($urandom_range(7));
      r_rb    = ($urandom_range(3) == 0) ? r_waddr : 3'($urandom_range(7));
      r_q.push_back(model_read(r_ra));
      r_q.push_back(model_read(r_rb));
      #1;
      e = r_q.pop_front();
      checks++;
      if (r_rda !== e) begin
        failures++;
        $display("FAIL random cycle%0d port_a addr %0d got %h want %h", c, r_ra, r_rda, e);
      end
      e = r_q.pop_front();
      checks++;
      if (r_rdb !== e) begin
        failures++;
        $display("FAIL random cycle%0d port_b addr %0d got %h want %h", c, r_rb, r_rdb, e);
      end
      if (r_reset) begin
        for (int i = 0; i < 8; i++) model[i] = 16'h0;
        model[5] = 16'hEFFC;
        model[6] = 16'h8000;
      end else if (r_we && r_waddr != 3'd0) begin
        if (r_wbe[0]) model[r_waddr][7:0]  = r_wdata[7:0];
        if (r_wbe[1]) model[r_waddr][15:8] = r_wdata[15:8];
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wbe = 4'h0; waddr = 5'd0; wdata = 32'h0;
    raddr_a = 5'd0; raddr_b = 5'd0;
    r_reset = 1'b1; r_we = 1'b0; r_wbe = 2'b0; r_waddr = 3'd0; r_wdata = 16'h0;
    r_ra = 3'd0; r_rb = 3'd0;
    test_reset();
    test_write_bytes();
    test_zero_reg();
    test_bypass();
    test_no_write();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
